// File: rtl/alu_datapath_sequencer.sv
// Multi-cycle control FSM for the regfile/ALU datapath: accepts a
// command, then steps readnum/load/ALUop/write controls to completion.
//
// Ports:
//   clk, reset        clock, async active-high reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_op/rd/rn/rm   command opcode and register numbers
//   readnum/writenum  register-file addresses
//   write, loada/b/c  register-file write, A/B/C register loads
//   loads             status (zero flag) register load
//   asel, bsel, vsel  datapath muxes; ALUop selects the ALU function
//   done, err         one-cycle completion / rejection pulses
module alu_datapath_sequencer #(
  parameter int RN_W = 3,
  parameter int OP_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [RN_W-1:0] cmd_rd,
  input  logic [RN_W-1:0] cmd_rn,
  input  logic [RN_W-1:0] cmd_rm,
  output logic [RN_W-1:0] readnum,
  output logic [RN_W-1:0] writenum,
  output logic            write,
  output logic            loada,
  output logic            loadb,
  output logic            asel,
  output logic            bsel,
  output logic [OP_W-1:0] ALUop,
  output logic            loadc,
  output logic            loads,
  output logic            vsel,
  output logic            done,
  output logic            err
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_MOV  = 3'b011;
  localparam logic [2:0] OP_CMP  = 3'b100;
  localparam logic [2:0] OP_MOVI = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDA,
    S_LDB,
    S_EXEC,
    S_WB,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [2:0]      op_q;
  logic [RN_W-1:0] rd_q;
  logic [RN_W-1:0] rn_q;
  logic [RN_W-1:0] rm_q;

  logic accept;
  logic is_add;
  logic is_sub;
  logic is_and;
  logic is_mov;
  logic is_cmp;
  logic is_movi;

  assign accept  = (state == S_IDLE) && cmd_valid;
  assign is_add  = (op_q == OP_ADD);
  assign is_sub  = (op_q == OP_SUB);
  assign is_and  = (op_q == OP_AND);
  assign is_mov  = (op_q == OP_MOV);
  assign is_cmp  = (op_q == OP_CMP);
  assign is_movi = (op_q == OP_MOVI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      op_q  <= '0;
      rd_q  <= '0;
      rn_q  <= '0;
      rm_q  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q <= cmd_op;
        rd_q <= cmd_rd;
        rn_q <= cmd_rn;
        rm_q <= cmd_rm;
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_ADD, OP_SUB, OP_AND,
            OP_CMP, OP_MOV:  state_n = S_LDA;
            OP_MOVI:         state_n = S_WB;
            default:         state_n = S_ERR;
          endcase
        end
      end
      S_LDA:   state_n = is_mov ? S_EXEC : S_LDB;
      S_LDB:   state_n = S_EXEC;
      S_EXEC:  state_n = is_cmp ? S_DONE : S_WB;
      S_WB:    state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    readnum   = '0;
    writenum  = '0;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    ALUop     = '0;
    loadc     = 1'b0;
    loads     = 1'b0;
    vsel      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state)
      S_IDLE: cmd_ready = 1'b1;
      S_LDA: begin
        readnum = rn_q;
        loada   = 1'b1;
      end
      S_LDB: begin
        readnum = rm_q;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        loadc = !is_cmp;
        loads = !is_mov;
        // CMP reuses the SUB path; only the flag is kept.
        unique case (1'b1)
          is_add:  ALUop = OP_W'(2'b00);
          is_sub:  ALUop = OP_W'(2'b01);
          is_and:  ALUop = OP_W'(2'b10);
          is_cmp:  ALUop = OP_W'(2'b01);
          is_mov:  ALUop = OP_W'(2'b11);
          default: ALUop = '0;
        endcase
      end
      S_WB: begin
        writenum = rd_q;
        write    = 1'b1;
        vsel     = is_movi;
      end
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: cmd_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_datapath_sequencer.sv
// Bench for alu_datapath_sequencer: small datapath model driven by
// the DUT controls, a vector table, plus multi-cycle corner sequences.
module tb_alu_datapath_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [2:0]  cmd_rd = '0;
  logic [2:0]  cmd_rn = '0;
  logic [2:0]  cmd_rm = '0;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        asel;
  logic        bsel;
  logic [1:0]  ALUop;
  logic        loadc;
  logic        loads;
  logic        vsel;
  logic        done;
  logic        err;
  logic [15:0] datapath_in = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_datapath_sequencer #(.RN_W(3), .OP_W(2)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd),
    .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .readnum(readnum), .writenum(writenum),
    .write(write), .loada(loada), .loadb(loadb),
    .asel(asel), .bsel(bsel), .ALUop(ALUop),
    .loadc(loadc), .loads(loads), .vsel(vsel),
    .done(done), .err(err)
  );

  // Datapath model: regfile, A, B, C and zero flag.
  logic [15:0] rf [8] = '{default: 16'h0};
  logic [15:0] ra = '0;
  logic [15:0] rb = '0;
  logic [15:0] rc = '0;
  logic        zf = 1'b0;
  logic [15:0] ain;
  logic [15:0] alu;

  always_comb begin
    ain = asel ? 16'h0 : ra;
    case (ALUop)
      2'b00:   alu = ain + rb;
      2'b01:   alu = ain - rb;
      2'b10:   alu = ain & rb;
      default: alu = ain;
    endcase
  end

  always @(posedge clk) begin
    if (loada) ra <= rf[readnum];
    if (loadb) rb <= rf[readnum];
    if (loadc) rc <= alu;
    if (loads) zf <= (alu == 16'h0);
    if (write) rf[writenum] <= vsel ? datapath_in : rc;
  end

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [15:0] din;
    int          lat;
    int          ridx;
    logic [15:0] rval;
    logic        z;
    int          wr;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [18:0] pk();
    return {cmd_ready, readnum, writenum, write,
            loada, loadb, asel, bsel, ALUop,
            loadc, loads, vsel, done, err};
  endfunction

  function automatic logic [18:0] mk(
    input logic rdy, input logic [2:0] rn,
    input logic [2:0] wn, input logic wr,
    input logic la, input logic lb,
    input logic [1:0] op, input logic lc,
    input logic ls, input logic vs,
    input logic dn, input logic er);
    return {rdy, rn, wn, wr, la, lb, 1'b0, 1'b0,
            op, lc, ls, vs, dn, er};
  endfunction

  // Called at a negedge; returns just after the accept edge.
  task automatic issue(input logic [2:0] op,
                       input logic [2:0] rd,
                       input logic [2:0] rn,
                       input logic [2:0] rm);
    int k = 0;
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_rd = rd;
    cmd_rn = rn;
    cmd_rm = rm;
    @(posedge clk);
  endtask

  task automatic drop();
    cmd_valid = 1'b0;
    cmd_op = 3'b111;
    cmd_rd = 3'b111;
    cmd_rn = 3'b111;
    cmd_rm = 3'b111;
  endtask

  task automatic run_vec(input int i);
    int lat = 0;
    int w = 0;
    datapath_in = tbl[i].din;
    issue(tbl[i].op, tbl[i].rd, tbl[i].rn, tbl[i].rm);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) drop();
      if (write) w++;
      if (done) begin
        lat = n;
        break;
      end
    end
    chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
    chk($sformatf("v%0d_reg", i),
        32'(rf[tbl[i].ridx]), 32'(tbl[i].rval));
    chk($sformatf("v%0d_z", i), 32'(zf), 32'(tbl[i].z));
    chk($sformatf("v%0d_wr", i), 32'(w), 32'(tbl[i].wr));
  endtask

  logic [18:0] idle_pat;
  logic [18:0] exp_seq [5];
  int          hits;
  int          d1;
  int          d2;

  initial begin
    idle_pat = mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    tbl[0]  = '{3'd5, 3'd3, 3'd0, 3'd0, 16'h0007,
                2, 3, 16'h0007, 1'b0, 1};
    tbl[1]  = '{3'd5, 3'd5, 3'd0, 3'd0, 16'h0002,
                2, 5, 16'h0002, 1'b0, 1};
    tbl[2]  = '{3'd0, 3'd2, 3'd3, 3'd5, 16'h0,
                5, 2, 16'h0009, 1'b0, 1};
    tbl[3]  = '{3'd1, 3'd4, 3'd3, 3'd5, 16'h0,
                5, 4, 16'h0005, 1'b0, 1};
    tbl[4]  = '{3'd2, 3'd6, 3'd3, 3'd5, 16'h0,
                5, 6, 16'h0002, 1'b0, 1};
    tbl[5]  = '{3'd4, 3'd7, 3'd1, 3'd1, 16'h0,
                4, 7, 16'h0000, 1'b1, 0};
    tbl[6]  = '{3'd3, 3'd1, 3'd3, 3'd0, 16'h0,
                4, 1, 16'h0007, 1'b1, 1};
    tbl[7]  = '{3'd1, 3'd0, 3'd5, 3'd3, 16'h0,
                5, 0, 16'hFFFB, 1'b0, 1};
    tbl[8]  = '{3'd4, 3'd6, 3'd3, 3'd4, 16'h0,
                4, 6, 16'h0002, 1'b0, 0};
    tbl[9]  = '{3'd5, 3'd0, 3'd0, 3'd0, 16'h0,
                2, 0, 16'h0000, 1'b0, 1};
    tbl[10] = '{3'd0, 3'd3, 3'd3, 3'd3, 16'h0,
                5, 3, 16'h000E, 1'b0, 1};

    repeat (2) @(negedge clk);
    chk("reset_outs", 32'(pk()), 32'(idle_pat));
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(i);

    // ADD r7 = r3 + r5 (14 + 2), control checked per cycle.
    exp_seq[0] = mk(0, 3, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
    exp_seq[1] = mk(0, 5, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0);
    exp_seq[2] = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0);
    exp_seq[3] = mk(0, 0, 7, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    exp_seq[4] = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
    issue(3'd0, 3'd7, 3'd3, 3'd5);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (n == 0) drop();
      chk($sformatf("add_c%0d", n + 1),
          32'(pk()), 32'(exp_seq[n]));
    end
    chk("add_r7", 32'(rf[7]), 32'h10);

    // Reset while ADD r6 = r1 + r1 sits in EXEC.
    issue(3'd0, 3'd6, 3'd1, 3'd1);
    @(negedge clk);
    drop();
    repeat (2) @(negedge clk);
    chk("rst_in_exec", 32'(loadc), 32'd1);
    #1 reset = 1'b1;
    #1 chk("rst_async", 32'(pk()), 32'(idle_pat));
    @(negedge clk);
    reset = 1'b0;
    hits = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (write || done) hits++;
    end
    chk("rst_no_wr", 32'(hits), 32'd0);
    chk("rst_r6", 32'(rf[6]), 32'h2);

    // Illegal opcodes: single err pulse, then idle.
    for (int k = 6; k < 8; k++) begin
      issue(3'(k), 3'd2, 3'd2, 3'd2);
      @(negedge clk);
      drop();
      chk($sformatf("err%0d_c1", k), 32'(pk()),
          32'(mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1)));
      @(negedge clk);
      chk($sformatf("err%0d_c2", k),
          32'(pk()), 32'(idle_pat));
    end
    chk("err_r2", 32'(rf[2]), 32'h9);

    // cmd_valid held: ADD r2=r3+r5 then ADD r4=r1+r5.
    issue(3'd0, 3'd2, 3'd3, 3'd5);
    d1 = 0;
    d2 = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n == 1) begin
        cmd_rd = 3'd4;
        cmd_rn = 3'd1;
        cmd_rm = 3'd5;
      end
      if (n == 5) chk("b2b_busy", 32'(cmd_ready), 32'd0);
      if (n == 6) chk("b2b_idle", 32'(cmd_ready), 32'd1);
      if (n == 7) drop();
      if (done && d1 == 0) d1 = n;
      else if (done && d2 == 0) d2 = n;
    end
    chk("b2b_done1", 32'(d1), 32'd5);
    chk("b2b_done2", 32'(d2), 32'd11);
    chk("b2b_r2", 32'(rf[2]), 32'h10);
    chk("b2b_r4", 32'(rf[4]), 32'h9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
